// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    function automatic int burst_width(input int burst_max);
        return $clog2(burst_max + 1);
    endfunction

endpackage

// File: rtl/fifo_wput_arbiter_if.sv
// Requester-side and FIFO-side signals of the write-port arbiter.
interface fifo_wput_arbiter_if #(
    parameter int DATA_SIZE = 8,
    parameter int NREQ      = 4
);
    import fifo_arb_pkg::*;

    localparam int ID_W = id_width(NREQ);

    logic [NREQ-1:0]           req;
    logic [NREQ*DATA_SIZE-1:0] req_data;
    logic [NREQ-1:0]           req_ack;
    logic [DATA_SIZE-1:0]      wdata;
    logic                      wput;
    logic                      wrdy;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;

    // Environment side: requesters plus the FIFO's ready flag.
    modport master (
        output req, req_data, wrdy,
        input  req_ack, wdata, wput, grant_id, busy
    );

    // Arbiter side.
    modport slave (
        input  req, req_data, wrdy,
        output req_ack, wdata, wput, grant_id, busy
    );

endinterface

// File: rtl/fifo_rr_pick.sv
// Round-robin picker: first set request after last_id, last_id itself examined last.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] last_id_i,
    output logic [ID_W-1:0] winner_o,
    output logic            found_o
);

    int idx;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        idx      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_id_i) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found_o && req_i[idx[ID_W-1:0]]) begin
                found_o  = 1'b1;
                winner_o = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wput_arbiter.sv
// Round-robin, burst-limited scheduler sharing one FIFO write port among NREQ requesters.
module fifo_wput_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int NREQ      = 4,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wput_arbiter_if.slave bus
);

    localparam int ID_W = id_width(NREQ);
    localparam int BW   = burst_width(BURST_MAX);

    localparam logic [0:0] ST_IDLE = 1'(IDLE);
    localparam logic [0:0] ST_HOLD = 1'(HOLD);

    logic [0:0]           state_q;
    logic [ID_W-1:0]      last_id_q;
    logic [BW-1:0]        burst_q;
    logic                 wput_q;
    logic                 busy_q;
    logic [NREQ-1:0]      ack_q;
    logic [DATA_SIZE-1:0] wdata_q;
    logic [ID_W-1:0]      grant_q;

    logic [ID_W-1:0]      rr_id;
    logic                 rr_found;
    logic                 cont;
    logic                 grant;
    logic [ID_W-1:0]      win_id;
    logic [BW-1:0]        burst_d;
    logic [DATA_SIZE-1:0] wdata_d;
    logic [NREQ-1:0]      ack_d;

    fifo_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req_i     (bus.req),
        .last_id_i (last_id_q),
        .winner_o  (rr_id),
        .found_o   (rr_found)
    );

    // A non-zero burst count means the previous grant went to last_id with no idle gap.
    always_comb begin
        cont  = bus.req[last_id_q] && (burst_q != '0) && (burst_q < BW'(BURST_MAX));
        grant = (state_q == ST_IDLE) && bus.wrdy && rr_found;
        win_id = cont ? last_id_q : rr_id;
        if (cont)
            burst_d = burst_q + 1'b1;
        else if ((rr_id == last_id_q) && (burst_q != '0))
            burst_d = burst_q;
        else
            burst_d = BW'(1);
        wdata_d = '0;
        ack_d   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == ID_W'(i)) begin
                wdata_d  = bus.req_data[i*DATA_SIZE +: DATA_SIZE];
                ack_d[i] = grant;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_id_q <= ID_W'(NREQ - 1);
            burst_q   <= '0;
            wput_q    <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= '0;
            wdata_q   <= '0;
            grant_q   <= '0;
        end else begin
            wput_q <= grant;
            ack_q  <= ack_d;
            busy_q <= (state_q == ST_HOLD);
            if (grant) begin
                wdata_q   <= wdata_d;
                grant_q   <= win_id;
                last_id_q <= win_id;
            end
            if (state_q == ST_IDLE)
                burst_q <= grant ? burst_d : '0;
            // HOLD always lasts one cycle, covering the FIFO's wrdy update after a put.
            state_q <= grant ? ST_HOLD : ST_IDLE;
        end
    end

    assign bus.wput     = wput_q;
    assign bus.req_ack  = ack_q;
    assign bus.wdata    = wdata_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = busy_q;

endmodule

// File: doc/fifo_wput_arbiter.md
Name: fifo_wput_arbiter

Overview:
- Write-side scheduler for the 2-deep clock-crossing FIFO. Lives entirely in the FIFO's write clock domain.
- Shares the single wput/wrdy/wdata write port among NREQ requesters, using round-robin with a bounded burst lock.
- Presents one registered, single-cycle wput per accepted word and acks the winning requester in the same cycle.

Parameters:
- DATA_SIZE, 8, width of each data word; matches the FIFO data width.
- NREQ, 4, number of requesters (2..8).
- BURST_MAX, 4, maximum consecutive grants to one requester while others are waiting (>=1).

Ports:
- clk  input  1  write-domain clock; same net as the FIFO wclk.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester word-valid; held with req_data until acked.
- req_data  input  NREQ*DATA_SIZE  requester i drives bits [i*DATA_SIZE +: DATA_SIZE].
- req_ack  output  NREQ  one-cycle pulse: requester's word has been written.
- wdata  output  DATA_SIZE  data to the FIFO write port.
- wput  output  1  one-cycle write strobe to the FIFO.
- wrdy  input  1  FIFO can accept a word.
- grant_id  output  $clog2(NREQ)  id of the last granted requester.
- busy  output  1  high in the HOLD state.

Behaviour:
- Reset (rst=1 at posedge), all outputs registered:
  - wput=0, req_ack=0, wdata=0, grant_id=0, busy=0.
  - Round-robin pointer last_id=NREQ-1, so requester 0 has top priority first.
  - burst_cnt=0, state=IDLE.
- FSM, two states:
  - IDLE:
    - If wrdy=1 and |req, select a winner W.
    - Next cycle: wput=1, wdata=req_data[W], req_ack[W]=1, grant_id=W, last_id=W, state=HOLD.
    - Otherwise wput=0 and the FSM stays in IDLE.
  - HOLD: exactly one cycle.
    - wput=0, req_ack=0, busy=1.
    - wrdy is ignored, covering the FIFO's one-cycle wrdy update after a put. Then go to IDLE.
- Throughput and latency:
  - At most one word every 2 cycles.
  - Latency from req&&wrdy sampled in IDLE to wput/ack: 1 cycle.
- Winner selection:
  - Burst continuation: if req[last_id]=1, burst_cnt<BURST_MAX, and the previous grant was last_id, then W=last_id and burst_cnt increments.
  - Otherwise W is the first set req bit scanning last_id+1, last_id+2, ... modulo NREQ, wrapping with last_id itself examined last. burst_cnt=1.
  - Lone requester: if it is the only one requesting, it is re-granted indefinitely. burst_cnt saturates at BURST_MAX and never blocks a lone requester.
  - burst_cnt clears to 0 on any IDLE cycle with no grant.
- Requester protocol:
  - req_data must be stable while req=1 and no ack has been received.
  - After an ack, the requester may hold req high with new data; it is sampled no earlier than the next IDLE cycle.
  - Dropping req before an ack is legal; no word is written for it.
- Boundary cases:
  - FIFO full (wrdy=0): no grant, no ack, requests wait; no starvation ordering is lost.
  - Simultaneous req from all requesters: strict rotation 0,1,2,3,... when BURST_MAX=1. With BURST_MAX=4 and all holding req, a requester gets at most 4 consecutive words.
  - wrdy deasserting in the same cycle as a grant decision: the decision uses the sampled wrdy. The FIFO must not drop wrdy without a put, so this case is excluded by FIFO protocol.
  - Reset mid-HOLD: next cycle is IDLE with reset values. A word already strobed stays written, and its ack was already given.
- Arithmetic:
  - Pointer increment wraps modulo NREQ (non-power-of-2 NREQ supported by explicit compare).
  - burst_cnt width is $clog2(BURST_MAX+1).

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum {IDLE, HOLD};
  - a function computing ID_W=$clog2(NREQ);
  - the burst counter width helper.
- One combinational sub-module, fifo_rr_pick:
  - inputs: req vector, last_id;
  - outputs: winner id and a found flag.
- The burst-lock override and all registers stay in the top block.

Test Plan:
- Reset then req=4'b0001, data0=8'hA5, wrdy=1 -> 1 cycle later wput=1, wdata=A5, req_ack=0001, grant_id=0; next cycle busy=1, wput=0.
- req=4'b1111 held, wrdy=1 always, BURST_MAX=1 -> grant_id sequence 0,1,2,3,0 on successive wput (every 2nd cycle).
- req=4'b1111 held, BURST_MAX=4 -> grant_id 0,0,0,0,1,1,1,1,2...
- Lone req[2] held, BURST_MAX=2 -> 6 consecutive wputs all grant_id=2, no gaps beyond the HOLD cycle.
- wrdy=0 for 10 cycles with req=4'b0110 -> no wput/ack. wrdy=1 -> grant_id=1 first, then 2.
- rst=1 asserted during HOLD -> next cycle all outputs 0, and grant restarts at requester 0 when req=4'b1111.
